// File: rtl/sobel_window_ci.sv
`default_nettype none
// ============================================================================
// Module   : sobel_window_ci
// Purpose  : Custom-instruction block that streams grayscale pixels through
//            two line buffers and keeps a 3x3 window for a Sobel instruction.
//            Ops: CONFIG (set width), PUSH (insert pixel), READ_A / READ_B
//            (export window bytes).
// Revision : 1.0 - initial release
// ============================================================================
module sobel_window_ci #(
  parameter logic [7:0]  customInstructionId = 8'd1,
  parameter int unsigned maxWidth            = 640
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  input  logic [7:0]  iseId,
  output logic        done,
  output logic [31:0] result
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_FETCH   = 2'd1;
  localparam logic [1:0] S_SHIFT   = 2'd2;

  localparam logic [1:0] OP_CONFIG = 2'd0;
  localparam logic [1:0] OP_PUSH   = 2'd1;
  localparam logic [1:0] OP_READ_A = 2'd2;
  localparam logic [1:0] OP_READ_B = 2'd3;

  // Column/row/width counters are 10 bits, so maxWidth must not exceed 1023.
  localparam logic [9:0] C_MAX_W   = 10'(maxWidth);
  localparam logic [9:0] C_ROW_MAX = 10'd1023;

  logic [1:0]       state_q, state_d;
  logic             done_q, done_d;
  logic [31:0]      result_q, result_d;
  logic [9:0]       width_q, width_d;
  logic [9:0]       col_q, col_d;
  logic [9:0]       row_q, row_d;
  logic [9:0]       addr_q, addr_d;
  logic [7:0]       pix_q, pix_d;
  // Window bytes p0..p8, index k = 3*row + column (left to right, top down).
  logic [8:0][7:0]  win_q, win_d;

  // Line buffers: lb1 holds row r-2, lb0 holds row r-1. Never reset; stale
  // contents are hidden by the valid flag until two full rows have passed.
  logic [7:0]       lb0 [maxWidth];
  logic [7:0]       lb1 [maxWidth];
  logic [7:0]       lb0_rd_q, lb1_rd_q;

  logic             w_accept;
  logic [1:0]       w_op;
  logic [9:0]       w_cfg_w;
  logic             w_cfg_ok;
  logic             w_valid;
  logic             unused_bits;

  assign w_accept    = start && (iseId == customInstructionId) && (state_q == S_IDLE);
  assign w_op        = valueB[1:0];
  assign w_cfg_w     = valueA[9:0];
  assign w_cfg_ok    = (w_cfg_w >= 10'd3) && (w_cfg_w <= C_MAX_W);
  // Windows at column 0..1 straddle the previous line, so they are not valid.
  assign w_valid     = (row_q >= 10'd2) && (col_q >= 10'd2);
  assign unused_bits = ^{valueA[31:10], valueB[31:2]};

  assign done   = done_q;
  assign result = result_q;

  // State register: an asynchronous reset aborts any PUSH in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: only PUSH leaves IDLE; other ops complete in one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (w_accept && (w_op == OP_PUSH)) state_d = S_FETCH;
      S_FETCH: state_d = S_SHIFT;
      S_SHIFT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next-state: result is zero in every non-done cycle.
  always_comb begin
    done_d   = 1'b0;
    result_d = 32'd0;
    width_d  = width_q;
    col_d    = col_q;
    row_d    = row_q;
    addr_d   = addr_q;
    pix_d    = pix_q;
    win_d    = win_q;
    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          case (w_op)
            OP_CONFIG: begin
              done_d = 1'b1;
              if (w_cfg_ok) begin
                width_d = w_cfg_w;
                col_d   = 10'd0;
                row_d   = 10'd0;
                win_d   = '0;
              end else begin
                result_d = 32'hFFFF_FFFF;
              end
            end
            OP_PUSH: begin
              pix_d  = valueA[7:0];
              addr_d = col_q;
            end
            OP_READ_A: begin
              done_d   = 1'b1;
              result_d = {win_q[3], win_q[2], win_q[1], win_q[0]};
            end
            default: begin
              done_d   = 1'b1;
              result_d = {win_q[8], win_q[7], win_q[6], win_q[5]};
            end
          endcase
        end
      end
      S_SHIFT: begin
        win_d[0] = win_q[1];
        win_d[1] = win_q[2];
        win_d[2] = lb1_rd_q;
        win_d[3] = win_q[4];
        win_d[4] = win_q[5];
        win_d[5] = lb0_rd_q;
        win_d[6] = win_q[7];
        win_d[7] = win_q[8];
        win_d[8] = pix_q;
        if (col_q == width_q - 10'd1) begin
          col_d = 10'd0;
          if (row_q != C_ROW_MAX) row_d = row_q + 10'd1;
        end else begin
          col_d = col_q + 10'd1;
        end
        done_d   = 1'b1;
        result_d = {w_valid, 5'd0, row_q, 6'd0, col_q};
      end
      default: ;
    endcase
  end

  // Datapath registers with asynchronous reset to the power-on configuration.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      done_q   <= 1'b0;
      result_q <= 32'd0;
      width_q  <= C_MAX_W;
      col_q    <= 10'd0;
      row_q    <= 10'd0;
      addr_q   <= 10'd0;
      pix_q    <= 8'd0;
      win_q    <= '0;
    end else begin
      done_q   <= done_d;
      result_q <= result_d;
      width_q  <= width_d;
      col_q    <= col_d;
      row_q    <= row_d;
      addr_q   <= addr_d;
      pix_q    <= pix_d;
      win_q    <= win_d;
    end
  end

  // Line-buffer RAMs: read in FETCH, rotate rows down in SHIFT.
  always_ff @(posedge clock) begin
    if (state_q == S_FETCH) begin
      lb0_rd_q <= lb0[addr_q];
      lb1_rd_q <= lb1[addr_q];
    end
    if (state_q == S_SHIFT) begin
      lb1[addr_q] <= lb0_rd_q;
      lb0[addr_q] <= pix_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sobel_window_ci.sv
`default_nettype none
// ============================================================================
// Module   : tb_sobel_window_ci
// Purpose  : Self-checking bench for sobel_window_ci. Expected results are
//            queued when an instruction is issued and compared on done.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sobel_window_ci;

  localparam logic [1:0] OP_CONFIG = 2'd0;
  localparam logic [1:0] OP_PUSH   = 2'd1;
  localparam logic [1:0] OP_READ_A = 2'd2;
  localparam logic [1:0] OP_READ_B = 2'd3;
  localparam int         LAT_ONE   = 1;
  localparam int         LAT_PUSH  = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] valueA = 32'd0;
  logic [31:0] valueB = 32'd0;
  logic [7:0]  iseId = 8'd0;
  logic        done;
  logic [31:0] result;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q [$];

  sobel_window_ci #(
    .customInstructionId(8'd1),
    .maxWidth(640)
  ) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .valueA(valueA),
    .valueB(valueB),
    .iseId (iseId),
    .done  (done),
    .result(result)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, required finish before 500us");
    $fatal(1);
  end

  // Drive one instruction and wait (bounded) for done; lat counts negedges.
  task automatic exec(input logic [1:0] op, input logic [31:0] a, input logic [7:0] id,
                      input bit b2b, output logic [31:0] got, output int lat);
    if (!b2b) @(negedge clock);
    start  = 1'b1;
    valueA = a;
    valueB = {30'd0, op};
    iseId  = id;
    @(negedge clock);
    start = 1'b0;
    got   = 'x;
    lat   = 99;
    for (int i = 1; i <= 8; i++) begin
      if (done) begin
        got = result;
        lat = i;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    logic [31:0] got, e;
    int lat;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", done); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h required 00000000", result); end
    reset = 1'b0;
    exp_q.push_back(32'h0000_0000);
    exec(OP_READ_A, 32'd0, 8'd1, 1'b0, got, lat);
    e = exp_q.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL reset_read_a: got %h required %h", got, e); end
    checks++; if (lat !== LAT_ONE) begin errors++; $display("FAIL reset_read_a_latency: got %0d required %0d", lat, LAT_ONE); end
    @(negedge clock);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_one_cycle: got %b required 0", done); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL result_idle_zero: got %h required 00000000", result); end
  endtask

  task automatic test_config_push();
    logic [31:0] got, e;
    int lat, idx;
    exp_q.push_back(32'd0);
    exec(OP_CONFIG, 32'd4, 8'd1, 1'b0, got, lat);
    e = exp_q.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL config_w4: got %h required %h", got, e); end
    checks++; if (lat !== LAT_ONE) begin errors++; $display("FAIL config_latency: got %0d required %0d", lat, LAT_ONE); end
    for (int n = 1; n <= 11; n++) begin
      idx = n - 1;
      exp_q.push_back({((idx / 4) >= 2 && (idx % 4) >= 2), 5'd0, 10'(idx / 4), 6'd0, 10'(idx % 4)});
      exec(OP_PUSH, 32'(n), 8'd1, 1'b0, got, lat);
      e = exp_q.pop_front();
      checks++; if (got !== e) begin errors++; $display("FAIL push_%0d: got %h required %h", n, got, e); end
      checks++; if (lat !== LAT_PUSH) begin errors++; $display("FAIL push_%0d_latency: got %0d required %0d", n, lat, LAT_PUSH); end
    end
    exp_q.push_back(32'h0503_0201);
    exec(OP_READ_A, 32'd0, 8'd1, 1'b0, got, lat);
    e = exp_q.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL read_a_after_11: got %h required %h", got, e); end
    exp_q.push_back(32'h0B0A_0907);
    exec(OP_READ_B, 32'd0, 8'd1, 1'b0, got, lat);
    e = exp_q.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL read_b_after_11: got %h required %h", got, e); end
    exp_q.push_back(32'h8002_0003);
    exec(OP_PUSH, 32'd12, 8'd1, 1'b0, got, lat);
    e = exp_q.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL push_12: got %h required %h", got, e); end
    exp_q.push_back(32'h0604_0302);
    exec(OP_READ_A, 32'd0, 8'd1, 1'b0, got, lat);
    e = exp_q.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL read_a_after_12: got %h required %h", got, e); end
    exp_q.push_back(32'h0C0B_0A08);
    exec(OP_READ_B, 32'd0, 8'd1, 1'b0, got, lat);
    e = exp_q.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL read_b_after_12: got %h required %h", got, e); end
    exp_q.push_back(32'h0003_0000);
    exec(OP_PUSH, 32'd13, 8'd1, 1'b0, got, lat);
    e = exp_q.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL push_13_wrap: got %h required %h", got, e); end
  endtask

  task automatic test_ignore();
    logic [31:0] got, e;
    int lat, ndone;
    // Wrong instruction id: nothing may happen.
    @(negedge clock);
    start = 1'b1; valueA = 32'd99; valueB = {30'd0, OP_PUSH}; iseId = 8'd0;
    @(negedge clock);
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 5; i++) begin
      if (done) ndone++;
      @(negedge clock);
    end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL wrong_id_done: got %0d dones required 0", ndone); end
    // Start held through FETCH: only the first request is taken.
    exp_q.push_back(32'h0003_0001);
    start = 1'b1; valueA = 32'd14; valueB = {30'd0, OP_PUSH}; iseId = 8'd1;
    @(negedge clock);
    @(negedge clock);
    start = 1'b0;
    ndone = 0;
    got = 'x;
    for (int i = 0; i < 6; i++) begin
      if (done) begin ndone++; got = result; end
      @(negedge clock);
    end
    e = exp_q.pop_front();
    checks++; if (ndone !== 1) begin errors++; $display("FAIL start_in_fetch_dones: got %0d required 1", ndone); end
    checks++; if (got !== e) begin errors++; $display("FAIL start_in_fetch_result: got %h required %h", got, e); end
    exp_q.push_back(32'h8003_0002);
    exec(OP_PUSH, 32'd15, 8'd1, 1'b0, got, lat);
    e = exp_q.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL counters_after_ignore: got %h required %h", got, e); end
  endtask

  task automatic test_bad_config();
    logic [31:0] got, e;
    int lat;
    exp_q.push_back(32'hFFFF_FFFF);
    exec(OP_CONFIG, 32'd2, 8'd1, 1'b0, got, lat);
    e = exp_q.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL config_w2: got %h required %h", got, e); end
    exp_q.push_back(32'hFFFF_FFFF);
    exec(OP_CONFIG, 32'd641, 8'd1, 1'b0, got, lat);
    e = exp_q.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL config_w641: got %h required %h", got, e); end
    exp_q.push_back(32'h8003_0003);
    exec(OP_PUSH, 32'd16, 8'd1, 1'b0, got, lat);
    e = exp_q.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL push_after_bad_cfg: got %h required %h", got, e); end
    exp_q.push_back(32'h0004_0000);
    exec(OP_PUSH, 32'd17, 8'd1, 1'b0, got, lat);
    e = exp_q.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL wrap_kept_w4: got %h required %h", got, e); end
  endtask

  // Random frame, width 5, all instructions issued in the done cycle of the
  // previous one; window contents derived from the frame image.
  task automatic test_back_to_back();
    logic [31:0] got, e;
    logic [7:0]  img [20];
    int lat, r, c;
    exp_q.push_back(32'd0);
    exec(OP_CONFIG, 32'd5, 8'd1, 1'b0, got, lat);
    e = exp_q.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL config_w5: got %h required %h", got, e); end
    for (int n = 0; n < 20; n++) begin
      img[n] = 8'($urandom_range(0, 255));
      r = n / 5;
      c = n % 5;
      exp_q.push_back({(r >= 2 && c >= 2), 5'd0, 10'(r), 6'd0, 10'(c)});
      exec(OP_PUSH, {24'd0, img[n]}, 8'd1, 1'b1, got, lat);
      e = exp_q.pop_front();
      checks++; if (got !== e) begin errors++; $display("FAIL b2b_push_%0d: got %h required %h", n, got, e); end
      checks++; if (lat !== LAT_PUSH) begin errors++; $display("FAIL b2b_push_%0d_latency: got %0d required %0d", n, lat, LAT_PUSH); end
      if (r >= 2 && c >= 2) begin
        exp_q.push_back({img[(r-1)*5+c-2], img[(r-2)*5+c], img[(r-2)*5+c-1], img[(r-2)*5+c-2]});
        exec(OP_READ_A, 32'd0, 8'd1, 1'b1, got, lat);
        e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL b2b_read_a_%0d: got %h required %h", n, got, e); end
        exp_q.push_back({img[r*5+c], img[r*5+c-1], img[r*5+c-2], img[(r-1)*5+c]});
        exec(OP_READ_B, 32'd0, 8'd1, 1'b1, got, lat);
        e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL b2b_read_b_%0d: got %h required %h", n, got, e); end
        checks++; if (lat !== LAT_ONE) begin errors++; $display("FAIL b2b_read_latency_%0d: got %0d required %0d", n, lat, LAT_ONE); end
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] got, e;
    int lat, ndone;
    @(negedge clock);
    start = 1'b1; valueA = 32'd77; valueB = {30'd0, OP_PUSH}; iseId = 8'd1;
    @(negedge clock);
    start = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 5; i++) begin
      if (done) ndone++;
      @(negedge clock);
    end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL abort_no_done: got %0d dones required 0", ndone); end
    exp_q.push_back(32'd0);
    exec(OP_READ_A, 32'd0, 8'd1, 1'b0, got, lat);
    e = exp_q.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL abort_read_a: got %h required %h", got, e); end
    exp_q.push_back(32'd0);
    exec(OP_READ_B, 32'd0, 8'd1, 1'b0, got, lat);
    e = exp_q.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL abort_read_b: got %h required %h", got, e); end
    exp_q.push_back(32'h0000_0000);
    exec(OP_PUSH, 32'd5, 8'd1, 1'b0, got, lat);
    e = exp_q.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL abort_push_pos: got %h required %h", got, e); end
    exp_q.push_back(32'h0000_0001);
    exec(OP_PUSH, 32'd6, 8'd1, 1'b0, got, lat);
    e = exp_q.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL abort_push_next: got %h required %h", got, e); end
  endtask

  initial begin
    test_reset();
    test_config_push();
    test_ignore();
    test_bad_config();
    test_back_to_back();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
